// File: rtl/uart_pkg.sv
// Shared types for the parameterised UART transmitter.
package uart_pkg;

  typedef enum logic [1:0] {
    NONE,
    ODD,
    EVEN
  } parity_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// Show-ahead TX word queue; count, full and empty are registered.
module uart_tx_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data_c,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count_d;
  logic             push_ok;
  logic             pop_ok;

  assign push_ok   = push && !full;
  assign pop_ok    = pop && !empty;
  assign rd_data_c = mem[rd_ptr];

  always_comb begin
    count_d = count;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count + CW'(1);
      2'b01:   count_d = count - CW'(1);
      default: ;
    endcase
  end

  // Storage is not reset; only pointers and occupancy define validity.
  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_d;
      full  <= (count_d == CW'(DEPTH));
      empty <= (count_d == '0);
    end
  end

endmodule

// File: rtl/uart_tx_param.sv
// Parameterised UART transmitter: queued writes, configurable data/parity/stop framing.
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BAUD = 54,
  parameter int unsigned DATA_BITS     = 8,
  parameter parity_t     PARITY        = NONE,
  parameter int unsigned STOP_BITS     = 1,
  parameter int unsigned FIFO_DEPTH    = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          send_uart_data,
  input  logic [DATA_BITS-1:0]          uart_data,
  output logic                          uart_ready,
  output logic                          uart_tx,
  output logic                          uart_data_sent,
  output logic                          tx_busy,
  output logic                          tx_overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned BAUD_W = $clog2(CLKS_PER_BAUD);
  localparam int unsigned BIT_W  = $clog2(DATA_BITS);
  localparam int unsigned SH_W   = DATA_BITS + 1;

  tx_state_t            state_q, state_d;
  logic [BAUD_W-1:0]    baud_q, baud_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [SH_W-1:0]      shift_q, shift_d;
  logic                 sent_pend_q;

  logic                 fifo_full, fifo_empty;
  logic [DATA_BITS-1:0] fifo_head_c;
  logic                 push_c, pop_c, stop_end_c, line_c, bit_end_c, parity_c;
  logic [SH_W-1:0]      load_c;

  assign push_c     = send_uart_data && !fifo_full;
  assign uart_ready = !fifo_full;
  assign bit_end_c  = (baud_q == BAUD_W'(CLKS_PER_BAUD - 1));
  // Parity rides above the data in the shift register and falls out after the last data bit.
  assign parity_c   = (^fifo_head_c) ^ (PARITY == ODD);
  assign load_c     = {parity_c, fifo_head_c};

  uart_tx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push_c),
    .pop       (pop_c),
    .wr_data   (uart_data),
    .rd_data_c (fifo_head_c),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_comb begin
    state_d    = state_q;
    baud_d     = bit_end_c ? '0 : baud_q + BAUD_W'(1);
    bit_d      = bit_q;
    shift_d    = shift_q;
    pop_c      = 1'b0;
    stop_end_c = 1'b0;
    line_c     = 1'b1;
    case (state_q)
      ST_IDLE: begin
        baud_d = '0;
        if (!fifo_empty) begin
          pop_c   = 1'b1;
          shift_d = load_c;
          state_d = ST_START;
        end
      end
      ST_START: begin
        line_c = 1'b0;
        if (bit_end_c) begin
          bit_d   = '0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        line_c = shift_q[0];
        if (bit_end_c) begin
          shift_d = {1'b1, shift_q[SH_W-1:1]};
          if (bit_q == BIT_W'(DATA_BITS - 1)) begin
            bit_d   = '0;
            state_d = (PARITY == NONE) ? ST_STOP : ST_PARITY;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
      ST_PARITY: begin
        line_c = shift_q[0];
        if (bit_end_c) begin
          bit_d   = '0;
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (bit_end_c) begin
          if (bit_q == BIT_W'(STOP_BITS - 1)) begin
            stop_end_c = 1'b1;
            bit_d      = '0;
            // Chain straight into the next frame when a word is waiting.
            if (!fifo_empty) begin
              pop_c   = 1'b1;
              shift_d = load_c;
              state_d = ST_START;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Line and done pulse lag the FSM by one cycle so the pulse marks the end of the driven stop bit.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      baud_q         <= '0;
      bit_q          <= '0;
      shift_q        <= '0;
      sent_pend_q    <= 1'b0;
      uart_tx        <= 1'b1;
      uart_data_sent <= 1'b0;
      tx_busy        <= 1'b0;
      tx_overflow    <= 1'b0;
    end else begin
      state_q        <= state_d;
      baud_q         <= baud_d;
      bit_q          <= bit_d;
      shift_q        <= shift_d;
      sent_pend_q    <= stop_end_c;
      uart_tx        <= line_c;
      uart_data_sent <= sent_pend_q;
      tx_busy        <= (state_d != ST_IDLE);
      tx_overflow    <= send_uart_data && fifo_full;
    end
  end

endmodule
